event_ingress_fifo: RTL and testbench

//  Ingress buffer between the DVS sensor interface and event_preprocessor. Captures raw events
//  (timestamp, x, y, polarity) from a source with no backpressure, discards out-of-window

---
 rtl/event_ingress_fifo.sv | 132 +++++++++++++
 tb/tb_event_ingress_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/event_ingress_fifo.sv
// DVS event ingress: coordinate-window filter and a DEPTH-entry FIFO feeding a registered output; push-to-valid takes 2 edges.
// Input has no backpressure: rejected events are counted as lost. The output holds while m_ready_i=0. Optional EVT_TS_MONOTONIC_EN.
module event_ingress_fifo #(
  parameter int TS_WIDTH    = 34,
  parameter int COORD_WIDTH = 14,
  parameter int MAX_X       = 63,
  parameter int MAX_Y       = 63,
  parameter int DEPTH       = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       s_valid_i,
  input  logic [TS_WIDTH-1:0]        s_timestamp_i,
  input  logic [COORD_WIDTH-1:0]     s_x_coord_i,
  input  logic [COORD_WIDTH-1:0]     s_y_coord_i,
  input  logic                       s_polarity_i,
  input  logic                       m_ready_i,
  output logic [TS_WIDTH-1:0]        timestamp_o,
  output logic [COORD_WIDTH-1:0]     x_coord_o,
  output logic [COORD_WIDTH-1:0]     y_coord_o,
  output logic                       polarity_o,
  output logic                       is_valid_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [CNT_WIDTH-1:0]       overflow_cnt_o,
  output logic [CNT_WIDTH-1:0]       filtered_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [COORD_WIDTH-1:0] MAX_X_C = COORD_WIDTH'(MAX_X);
  localparam logic [COORD_WIDTH-1:0] MAX_Y_C = COORD_WIDTH'(MAX_Y);

  logic [TS_WIDTH-1:0]    ts_mem_q [DEPTH];
  logic [COORD_WIDTH-1:0] x_mem_q  [DEPTH];
  logic [COORD_WIDTH-1:0] y_mem_q  [DEPTH];
  logic                   p_mem_q  [DEPTH];

  logic [PW-1:0]          wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CNT_WIDTH-1:0]   ovf_cnt_q, ovf_cnt_d, filt_cnt_q, filt_cnt_d;
  logic [TS_WIDTH-1:0]    ts_q, ts_d;
  logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic                   pol_q, pol_d, vld_q, vld_d;

  logic in_window, ts_ok, accept, full, empty, pop, can_push, push, filt, ovf;

  assign in_window = (s_x_coord_i <= MAX_X_C) && (s_y_coord_i <= MAX_Y_C);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop       = !empty && (!vld_q || m_ready_i);
  assign can_push  = !full || pop;

`ifdef EVT_TS_MONOTONIC_EN
  // Timestamp order is judged before fullness, so a stale event is never counted as an overflow.
  logic [TS_WIDTH-1:0] last_ts_q;
  assign ts_ok = (s_timestamp_i >= last_ts_q);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   last_ts_q <= '0;
    else if (push) last_ts_q <= s_timestamp_i;
  end
`else
  assign ts_ok = 1'b1;
`endif

  assign accept = s_valid_i && in_window && ts_ok;
  assign filt   = s_valid_i && !(in_window && ts_ok);
  assign push   = accept && can_push;
  assign ovf    = accept && !can_push;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_cnt_d  = (ovf  && ovf_cnt_q  != '1) ? ovf_cnt_q  + 1'b1 : ovf_cnt_q;
    filt_cnt_d = (filt && filt_cnt_q != '1) ? filt_cnt_q + 1'b1 : filt_cnt_q;
    ts_d  = ts_q;
    x_d   = x_q;
    y_d   = y_q;
    pol_d = pol_q;
    vld_d = vld_q;
    if (pop) begin
      ts_d  = ts_mem_q[rd_ptr_q[AW-1:0]];
      x_d   = x_mem_q[rd_ptr_q[AW-1:0]];
      y_d   = y_mem_q[rd_ptr_q[AW-1:0]];
      pol_d = p_mem_q[rd_ptr_q[AW-1:0]];
      vld_d = 1'b1;
    end else if (m_ready_i) begin
      vld_d = 1'b0;
    end
  end

  // Storage is not reset: only the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      ts_mem_q[wr_ptr_q[AW-1:0]] <= s_timestamp_i;
      x_mem_q[wr_ptr_q[AW-1:0]]  <= s_x_coord_i;
      y_mem_q[wr_ptr_q[AW-1:0]]  <= s_y_coord_i;
      p_mem_q[wr_ptr_q[AW-1:0]]  <= s_polarity_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_cnt_q  <= '0;
      filt_cnt_q <= '0;
      ts_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pol_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_cnt_q  <= ovf_cnt_d;
      filt_cnt_q <= filt_cnt_d;
      ts_q       <= ts_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pol_q      <= pol_d;
      vld_q      <= vld_d;
    end
  end

  assign timestamp_o    = ts_q;
  assign x_coord_o      = x_q;
  assign y_coord_o      = y_q;
  assign polarity_o     = pol_q;
  assign is_valid_o     = vld_q;
  assign level_o        = wr_ptr_q - rd_ptr_q;
  assign overflow_cnt_o = ovf_cnt_q;
  assign filtered_cnt_o = filt_cnt_q;
endmodule

// File: tb/tb_event_ingress_fifo.sv
// Bench for event_ingress_fifo: directed scenarios plus a random run against a queue-based reference model.
module tb_event_ingress_fifo;
  typedef struct packed {
    logic [33:0] ts;
    logic [13:0] x;
    logic [13:0] y;
    logic        p;
  } evt_t;

  logic        clk, rst_n, s_valid, s_p, m_ready;
  logic [33:0] s_ts;
  logic [13:0] s_x, s_y;
  logic [33:0] ts_o;
  logic [13:0] x_o, y_o;
  logic        p_o, vld_o;
  logic [4:0]  level_o;
  logic [15:0] ovf_o, filt_o;

  int errors = 0;
  int checks = 0;

  event_ingress_fifo dut (
    .clk_i(clk), .rst_ni(rst_n), .s_valid_i(s_valid), .s_timestamp_i(s_ts),
    .s_x_coord_i(s_x), .s_y_coord_i(s_y), .s_polarity_i(s_p), .m_ready_i(m_ready),
    .timestamp_o(ts_o), .x_coord_o(x_o), .y_coord_o(y_o), .polarity_o(p_o),
    .is_valid_o(vld_o), .level_o(level_o), .overflow_cnt_o(ovf_o), .filtered_cnt_o(filt_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference model: a queue of stored events plus the output slot and two counters.
  evt_t        mq[$];
  evt_t        mo;
  bit          mv;
  int          movf, mfilt;
  logic [33:0] mlast;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); mo = '0; mv = 0; movf = 0; mfilt = 0; mlast = '0;
    end else begin
      bit   popm, ok, pushm;
      evt_t e;
      popm  = (mq.size() != 0) && (!mv || m_ready);
      ok    = (s_x <= 63) && (s_y <= 63);
`ifdef EVT_TS_MONOTONIC_EN
      ok    = ok && (s_ts >= mlast);
`endif
      pushm = 0;
      e     = '{ts: s_ts, x: s_x, y: s_y, p: s_p};
      if (s_valid) begin
        if (!ok) mfilt = (mfilt == 65535) ? mfilt : mfilt + 1;
        else if (mq.size() < 16 || popm) pushm = 1;
        else movf = (movf == 65535) ? movf : movf + 1;
      end
      if (popm) begin mo = mq.pop_front(); mv = 1; end
      else if (m_ready) mv = 0;
      if (pushm) begin mq.push_back(e); mlast = s_ts; end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [33:0] ts, input int x, input int y, input logic p);
    s_valid = 1; s_ts = ts; s_x = 14'(x); s_y = 14'(y); s_p = p;
    tick();
    s_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; s_valid = 0; m_ready = 1;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; s_valid = 0; s_ts = '0; s_x = '0; s_y = '0; s_p = 0; m_ready = 1;
    tick(); tick();
    checks++;
    if ({vld_o, level_o, ovf_o, filt_o, ts_o, x_o, y_o, p_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: vld=%0b lvl=%0d ovf=%0d filt=%0d ts=%0d x=%0d y=%0d p=%0b, need all 0",
               vld_o, level_o, ovf_o, filt_o, ts_o, x_o, y_o, p_o);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    send(100, 5, 7, 1);
    checks++;
    if (vld_o !== 0 || level_o !== 1) begin
      errors++; $display("FAIL single_edge1: vld=%0b lvl=%0d, need 0/1", vld_o, level_o);
    end
    tick();
    checks++;
    if (vld_o !== 1 || ts_o !== 100 || x_o !== 5 || y_o !== 7 || p_o !== 1 || level_o !== 0) begin
      errors++;
      $display("FAIL single_out: vld=%0b ts=%0d x=%0d y=%0d p=%0b lvl=%0d, need 1/100/5/7/1/0",
               vld_o, ts_o, x_o, y_o, p_o, level_o);
    end
    tick();
    checks++;
    if (vld_o !== 0) begin errors++; $display("FAIL single_drop: vld=%0b, need 0", vld_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    m_ready = 0;
    for (int i = 0; i < 20; i++) send(34'(1000 + i), i, i, i[0]);
    checks++;
    if (level_o !== 16 || ovf_o !== 3 || vld_o !== 1 || ts_o !== 1000) begin
      errors++;
      $display("FAIL overflow_fill: lvl=%0d ovf=%0d vld=%0b ts=%0d, need 16/3/1/1000",
               level_o, ovf_o, vld_o, ts_o);
    end
    m_ready = 1;
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (vld_o !== 1 || ts_o !== 34'(1000 + i) || x_o !== 14'(i)) begin
        errors++;
        $display("FAIL overflow_order[%0d]: vld=%0b ts=%0d x=%0d, need 1/%0d/%0d", i, vld_o, ts_o, x_o, 1000 + i, i);
      end
      tick();
    end
    checks++;
    if (vld_o !== 0 || level_o !== 0 || ovf_o !== 3) begin
      errors++; $display("FAIL overflow_drain: vld=%0b lvl=%0d ovf=%0d, need 0/0/3", vld_o, level_o, ovf_o);
    end
  endtask

  task automatic test_filter();
    do_reset();
    send(1, 64, 0, 0);
    send(2, 0, 64, 1);
    tick();
    checks++;
    if (filt_o !== 2 || vld_o !== 0 || level_o !== 0 || ovf_o !== 0) begin
      errors++;
      $display("FAIL filter: filt=%0d vld=%0b lvl=%0d ovf=%0d, need 2/0/0/0", filt_o, vld_o, level_o, ovf_o);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    m_ready = 0;
    for (int i = 0; i < 17; i++) send(34'(10 + i), i, 1, 0);
    checks++;
    if (level_o !== 16) begin errors++; $display("FAIL fullpop_fill: lvl=%0d, need 16", level_o); end
    m_ready = 1;
    send(500, 3, 3, 1);
    checks++;
    if (level_o !== 16 || ovf_o !== 0 || ts_o !== 11) begin
      errors++; $display("FAIL fullpop_same_cycle: lvl=%0d ovf=%0d ts=%0d, need 16/0/11", level_o, ovf_o, ts_o);
    end
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (vld_o !== 1 || ts_o !== 500 || level_o !== 0) begin
      errors++; $display("FAIL fullpop_last: vld=%0b ts=%0d lvl=%0d, need 1/500/0", vld_o, ts_o, level_o);
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    m_ready = 0;
    for (int i = 0; i < 10; i++) send(34'(20 + i), i, 2, 1);
    checks++;
    if (level_o !== 9) begin errors++; $display("FAIL midburst_level: lvl=%0d, need 9", level_o); end
    #1 rst_n = 0;
    #1;
    checks++;
    if ({vld_o, level_o, ovf_o, filt_o, ts_o, x_o, y_o, p_o} !== '0) begin
      errors++; $display("FAIL midburst_async: vld=%0b lvl=%0d ts=%0d, need all 0", vld_o, level_o, ts_o);
    end
    @(negedge clk);
    rst_n = 1; m_ready = 1;
    send(100, 5, 7, 1);
    tick();
    checks++;
    if (vld_o !== 1 || ts_o !== 100 || x_o !== 5 || y_o !== 7 || p_o !== 1) begin
      errors++; $display("FAIL midburst_after: vld=%0b ts=%0d x=%0d, need 1/100/5", vld_o, ts_o, x_o);
    end
  endtask

`ifdef EVT_TS_MONOTONIC_EN
  task automatic test_ts_monotonic();
    logic [33:0] got[$];
    do_reset();
    m_ready = 0;
    send(50, 1, 1, 0); send(40, 1, 1, 0); send(50, 2, 2, 0); send(60, 3, 3, 0);
    m_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (vld_o === 1) got.push_back(ts_o);
      tick();
    end
    checks++;
    if (got.size() != 3 || got[0] !== 50 || got[1] !== 50 || got[2] !== 60 || filt_o !== 1) begin
      errors++;
      $display("FAIL ts_monotonic: n=%0d filt=%0d, need 3 events 50,50,60 and filt=1", got.size(), filt_o);
    end
  endtask
`endif

  task automatic test_random();
    logic [33:0] ts_run;
    int          bias;
    do_reset();
    ts_run = 34'd1000;
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if (vld_o !== mv || level_o !== 5'(mq.size()) || ovf_o !== 16'(movf) || filt_o !== 16'(mfilt) ||
          ts_o !== mo.ts || x_o !== mo.x || y_o !== mo.y || p_o !== mo.p) begin
        errors++;
        $display("FAIL random[%0d]: vld=%0b/%0b lvl=%0d/%0d ovf=%0d/%0d filt=%0d/%0d ts=%0d/%0d (got/need)",
                 c, vld_o, mv, level_o, mq.size(), ovf_o, movf, filt_o, mfilt, ts_o, mo.ts);
      end
      bias = (c / 500) % 3;
      m_ready = ($urandom_range(0, 9) < (bias == 0 ? 2 : (bias == 1 ? 9 : 5)));
      s_valid = ($urandom_range(0, 3) != 0);
      ts_run  = ($urandom_range(0, 7) == 0) ? ts_run - 34'($urandom_range(0, 5)) : ts_run + 34'($urandom_range(0, 3));
      s_ts    = ts_run;
      s_x     = 14'($urandom_range(0, 70));
      s_y     = ($urandom_range(0, 15) == 0) ? 14'($urandom_range(64, 16383)) : 14'($urandom_range(0, 63));
      s_p     = 1'($urandom_range(0, 1));
      tick();
    end
    s_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_filter();
    test_full_pop();
    test_reset_midburst();
`ifdef EVT_TS_MONOTONIC_EN
    test_ts_monotonic();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
